tmds_channel_encoder: RTL and testbench

TMDS_CHANNEL_ENCODER -- requirements
Module: tmds_channel_encoder

---
 rtl/tmds_channel_encoder.sv | 114 +++++++++++
 tb/tb_tmds_channel_encoder.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/tmds_channel_encoder.sv
// TMDS 8b/10b encoder for one DVI colour channel.
// Two register stages: transition-minimised q_m, then DC-balanced 10-bit symbol with running tally.
module tmds_channel_encoder (
  input  logic              pixel_clk_in,
  input  logic              rst_n_in,
  input  logic [7:0]        data_in,
  input  logic [1:0]        ctrl_in,
  input  logic              ve_in,
  output logic [9:0]        tmds_out,
  output logic signed [4:0] tally_out
);

  localparam logic [9:0] CTRL_00 = 10'b1101010100;
  localparam logic [9:0] CTRL_01 = 10'b0010101011;
  localparam logic [9:0] CTRL_10 = 10'b0101010100;
  localparam logic [9:0] CTRL_11 = 10'b1010101011;

  logic [3:0]        n1_data;
  logic              use_xnor;
  logic [8:0]        q_m_d;
  logic [8:0]        q_m_q;
  logic              ve_q;
  logic [1:0]        ctrl_q;

  logic [3:0]        n1_qm;
  logic signed [4:0] disp_qm;
  logic              q8;
  logic [9:0]        tmds_d;
  logic [9:0]        tmds_q;
  logic signed [4:0] tally_d;
  logic signed [4:0] tally_q;

  always_comb begin
    n1_data = '0;
    for (int i = 0; i < 8; i++) begin
      n1_data = n1_data + 4'(data_in[i]);
    end
  end

  assign use_xnor = (n1_data > 4'd4) || ((n1_data == 4'd4) && !data_in[0]);

  always_comb begin
    logic [8:0] chain;
    chain    = '0;
    chain[0] = data_in[0];
    for (int i = 1; i < 8; i++) begin
      chain[i] = use_xnor ? ~(chain[i-1] ^ data_in[i]) : (chain[i-1] ^ data_in[i]);
    end
    chain[8] = ~use_xnor;
    q_m_d    = chain;
  end

  // Control rides alongside q_m so blanking symbols stay aligned with data.
  always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      q_m_q  <= '0;
      ve_q   <= 1'b0;
      ctrl_q <= 2'b00;
    end else begin
      q_m_q  <= q_m_d;
      ve_q   <= ve_in;
      ctrl_q <= ctrl_in;
    end
  end

  always_comb begin
    n1_qm = '0;
    for (int i = 0; i < 8; i++) begin
      n1_qm = n1_qm + 4'(q_m_q[i]);
    end
  end

  // Ones minus zeros of q_m[7:0]: 2*N1q - 8, always even in -8..+8.
  assign disp_qm = $signed({n1_qm, 1'b0}) - 5'sd8;
  assign q8      = q_m_q[8];

  always_comb begin
    tmds_d  = tmds_q;
    tally_d = tally_q;
    if (!ve_q) begin
      unique case (ctrl_q)
        2'b00:   tmds_d = CTRL_00;
        2'b01:   tmds_d = CTRL_01;
        2'b10:   tmds_d = CTRL_10;
        default: tmds_d = CTRL_11;
      endcase
      tally_d = 5'sd0;
    end else if ((tally_q == 5'sd0) || (disp_qm == 5'sd0)) begin
      tmds_d  = {~q8, q8, q8 ? q_m_q[7:0] : ~q_m_q[7:0]};
      tally_d = q8 ? (tally_q + disp_qm) : (tally_q - disp_qm);
    end else if (((tally_q > 5'sd0) && (disp_qm > 5'sd0)) ||
                 ((tally_q < 5'sd0) && (disp_qm < 5'sd0))) begin
      tmds_d  = {1'b1, q8, ~q_m_q[7:0]};
      tally_d = tally_q + $signed({3'b000, q8, 1'b0}) - disp_qm;
    end else begin
      tmds_d  = {1'b0, q8, q_m_q[7:0]};
      tally_d = tally_q - (q8 ? 5'sd0 : 5'sd2) + disp_qm;
    end
  end

  always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      tmds_q  <= '0;
      tally_q <= 5'sd0;
    end else begin
      tmds_q  <= tmds_d;
      tally_q <= tally_d;
    end
  end

  assign tmds_out  = tmds_q;
  assign tally_out = tally_q;

endmodule

// File: tb/tb_tmds_channel_encoder.sv
// Scoreboard bench for tmds_channel_encoder: driver pushes model expectations, monitor pops one per cycle.
module tb_tmds_channel_encoder;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [7:0]        data_s = '0;
  logic [1:0]        ctrl_s = '0;
  logic              ve_s = 1'b0;
  logic [9:0]        tmds;
  logic signed [4:0] tally;

  typedef struct packed {
    logic [9:0] tmds;
    logic [4:0] tally;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   m_tally = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  bit   mon_on = 1'b1;

  tmds_channel_encoder dut (
    .pixel_clk_in (clk),
    .rst_n_in     (rst_n),
    .data_in      (data_s),
    .ctrl_in      (ctrl_s),
    .ve_in        (ve_s),
    .tmds_out     (tmds),
    .tally_out    (tally)
  );

  always #5 clk = ~clk;

  // Reference: DVI 1.0 encoding rules evaluated with integer counts.
  function automatic void ref_encode(input bit ve, input bit [1:0] c, input bit [7:0] d,
                                     inout int t, output bit [9:0] sym);
    int       n1, ones, zeros, q8;
    bit       use_xnor;
    bit [8:0] qm;
    sym = '0;
    if (!ve) begin
      case (c)
        2'b00:   sym = 10'b1101010100;
        2'b01:   sym = 10'b0010101011;
        2'b10:   sym = 10'b0101010100;
        default: sym = 10'b1010101011;
      endcase
      t = 0;
      return;
    end
    n1       = $countones(d);
    use_xnor = (n1 > 4) || (n1 == 4 && d[0] == 1'b0);
    qm       = '0;
    qm[0]    = d[0];
    for (int i = 1; i < 8; i++)
      qm[i] = use_xnor ? ~(qm[i-1] ^ d[i]) : (qm[i-1] ^ d[i]);
    qm[8] = !use_xnor;
    q8    = qm[8] ? 1 : 0;
    ones  = $countones(qm[7:0]);
    zeros = 8 - ones;
    if (t == 0 || ones == zeros) begin
      sym = {~qm[8], qm[8], qm[8] ? qm[7:0] : ~qm[7:0]};
      t   = t + ((q8 == 1) ? (ones - zeros) : (zeros - ones));
    end else if ((t > 0 && ones > zeros) || (t < 0 && zeros > ones)) begin
      sym = {1'b1, qm[8], ~qm[7:0]};
      t   = t + 2 * q8 + (zeros - ones);
    end else begin
      sym = {1'b0, qm[8], qm[7:0]};
      t   = t - 2 * (1 - q8) + (ones - zeros);
    end
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b at %0t", name, act[9:0], req[9:0], $time);
    end
  endtask

  task automatic push_exp(input bit [9:0] s, input int t);
    exp_t e;
    e.tmds  = s;
    e.tally = 5'(t);
    exp_q.push_back(e);
  endtask

  task automatic cyc(input bit ve, input bit [1:0] c, input bit [7:0] d);
    bit [9:0] s;
    @(negedge clk);
    ve_s = ve; ctrl_s = c; data_s = d;
    ref_encode(ve, c, d, m_tally, s);
    push_exp(s, m_tally);
  endtask

  task automatic cyc_fixed(input bit ve, input bit [1:0] c, input bit [7:0] d,
                           input bit [9:0] xs, input int xt);
    @(negedge clk);
    ve_s = ve; ctrl_s = c; data_s = d;
    push_exp(xs, xt);
    m_tally = xt;
  endtask

  // Release at a negedge: first symbol comes from cleared stage 1, second from idle ctrl-00 input.
  task automatic do_release();
    @(negedge clk);
    rst_n = 1'b1;
    ve_s = 1'b0; ctrl_s = 2'b00; data_s = 8'h00;
    m_tally = 0;
    push_exp(10'b1101010100, 0);
    push_exp(10'b1101010100, 0);
  endtask

  task automatic mid_reset();
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    exp_q.delete();
    m_tally = 0;
    #1;
    check("async_rst_tmds", 32'(tmds), 32'd0);
    check("async_rst_tally", 32'($unsigned(tally)), 32'd0);
    repeat (2) @(posedge clk);
    do_release();
  endtask

  always @(posedge clk) begin
    if (rst_n && mon_on) begin
      #1;
      if (rst_n) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL sb_underflow: DUT output %b with no expected entry at %0t", tmds, $time);
        end else begin
          mon_e = exp_q.pop_front();
          check("tmds", 32'(tmds), 32'(mon_e.tmds));
          check("tally", 32'($unsigned(tally)), 32'(mon_e.tally));
          n_checks++;
          if (int'(tally) < -8 || int'(tally) > 8) begin
            n_fail++;
            $display("FAIL tally_range: got %0d, expected -8..8 at %0t", tally, $time);
          end
        end
      end
    end
  end

  initial begin
    repeat (3) @(posedge clk);
    #2;
    check("reset_tmds", 32'(tmds), 32'd0);
    check("reset_tally", 32'($unsigned(tally)), 32'd0);

    do_release();
    repeat (3) cyc_fixed(1'b0, 2'b00, 8'h5A, 10'b1101010100, 0);
    cyc_fixed(1'b0, 2'b01, 8'h00, 10'b0010101011, 0);
    cyc_fixed(1'b0, 2'b10, 8'h00, 10'b0101010100, 0);
    cyc_fixed(1'b0, 2'b11, 8'h00, 10'b1010101011, 0);
    cyc_fixed(1'b1, 2'b11, 8'h00, 10'b0100000000, -8);
    cyc_fixed(1'b1, 2'b10, 8'h00, 10'b1111111111, 2);
    cyc_fixed(1'b0, 2'b00, 8'h00, 10'b1101010100, 0);
    cyc_fixed(1'b1, 2'b01, 8'hFF, 10'b1000000000, -8);
    cyc_fixed(1'b0, 2'b00, 8'h00, 10'b1101010100, 0);

    for (int i = 0; i < 1280; i++)
      cyc(1'b1, 2'($urandom_range(0, 3)), 8'($urandom));
    for (int i = 0; i < 6; i++)
      cyc(1'b0, 2'($urandom_range(0, 3)), 8'($urandom));

    for (int i = 0; i < 300; i++)
      cyc($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), 8'($urandom));

    for (int i = 0; i < 20; i++)
      cyc(1'b1, 2'b00, 8'($urandom));
    mid_reset();
    for (int i = 0; i < 40; i++)
      cyc(1'b1, 2'($urandom_range(0, 3)), 8'($urandom));
    cyc(1'b0, 2'b00, 8'h00);

    for (int i = 0; i < 8 && exp_q.size() != 0; i++)
      @(negedge clk);
    mon_on = 1'b0;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expected symbols never appeared, expected 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
